collatz_range_engine: RTL



---
 rtl/collatz_pkg.sv | 16 +
 rtl/collatz_iter.sv | 56 +++++
 rtl/collatz_range_engine.sv | 124 ++++++++++++
 3 files changed

// File: rtl/collatz_pkg.sv
// Shared types and widths for the Collatz range engine.
package collatz_pkg;

    localparam int VAL_W = 32;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/collatz_iter.sv
// Single-value Collatz datapath: load a value, step once per cycle until n <= 1.
// With COLLATZ_OVF_FLAG_EN it flags 3n+1 overflow and length saturation per step.
module collatz_iter
    import collatz_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [VAL_W-1:0] n_in,
    output logic             busy,
`ifdef COLLATZ_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic [CNT_W-1:0] len
);

    logic [VAL_W-1:0] n_q, n_d, n_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign busy   = |n_q[VAL_W-1:1];
    assign len    = cnt_q;
    assign n_next = n_q[0] ? (n_q + (n_q << 1) + VAL_W'(1)) : (n_q >> 1);

`ifdef COLLATZ_OVF_FLAG_EN
    // Smallest odd n whose 3n+1 no longer fits in 32 bits.
    localparam logic [VAL_W-1:0] OVF_THRESH = 32'h5555_5555;
    assign ovf = busy && !load && ((n_q[0] && (n_q >= OVF_THRESH)) || (cnt_q == CNT_MAX));
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        n_d   = n_q;
        cnt_d = cnt_q;
        if (load) begin
            n_d   = n_in;
            cnt_d = (n_in == '0) ? '0 : CNT_W'(1);
        end else if (busy) begin
            n_d = n_next;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            n_q   <= '0;
            cnt_q <= '0;
        end else begin
            n_q   <= n_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/collatz_range_engine.sv
// Range engine: computes Collatz lengths of RAM_WORDS consecutive values into a RAM and
// serves registered reads addressed by start. COLLATZ_OVF_FLAG_EN adds the sticky ovf output.
module collatz_range_engine
    import collatz_pkg::*;
#(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [31:0] start,
    output logic        done,
`ifdef COLLATZ_OVF_FLAG_EN
    output logic        ovf,
`endif
    output logic [15:0] count
);

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
    logic [VAL_W-1:0]         base_q, base_d;
    logic                     done_q;
    logic [CNT_W-1:0]         rd_q;
    logic [CNT_W-1:0]         ram [RAM_WORDS];
    logic                     load, we, busy;
    logic [CNT_W-1:0]         len;

`ifdef COLLATZ_OVF_FLAG_EN
    logic ovf_q, ovf_d, step_ovf;
`endif

    collatz_iter u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .n_in    (base_q + VAL_W'(idx_q)),
        .busy    (busy),
`ifdef COLLATZ_OVF_FLAG_EN
        .ovf     (step_ovf),
`endif
        .len     (len)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        load    = 1'b0;
        we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    base_d  = start;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_d = ITER;
            end
            ITER: begin
                if (!busy) state_d = WRITE;
            end
            WRITE: begin
                we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + RAM_ADDR_BITS'(1);
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            done_q  <= (state_d == DONE);
        end
    end

    // NOTE: the RAM array is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) ram[idx_q] <= len;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) rd_q <= '0;
        else          rd_q <= ram[start[RAM_ADDR_BITS-1:0]];
    end

`ifdef COLLATZ_OVF_FLAG_EN
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && go) ovf_d = 1'b0;
        else if (step_ovf)         ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    assign done  = done_q;
    assign count = rd_q;

endmodule
